// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back payload layout and hazard-unit
// control encodings used by stage registers.
package pipe_pkg;

    localparam int DATA_W       = 16;
    localparam int REGADDR_W    = 4;
    localparam int WB_PAYLOAD_W = 22;

    typedef struct packed {
        logic                 hlt;
        logic                 we;
        logic [REGADDR_W-1:0] dst_addr;
        logic [DATA_W-1:0]    dst_data;
    } wb_payload_t;

    localparam logic FLUSH_KILL = 1'b1;
    localparam logic STALL_HOLD = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count register: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake, optional skid
// entry, hazard stall/flush and saturating stall/transfer counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH         = WB_PAYLOAD_W,
    parameter bit SKID          = 1'b1,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             mValid_r;
    logic [WIDTH-1:0] mData_r;
    logic             kill_s;
    logic             hold_s;
    logic             take_s;
    logic             acc_s;
    logic             inReady_s;
    logic             stallInc_s;

    assign kill_s     = (flush == FLUSH_KILL);
    assign hold_s     = (stall == STALL_HOLD);
    assign out_valid  = mValid_r & ~hold_s;
    assign out_data   = mData_r;
    assign take_s     = out_valid & out_ready;
    assign acc_s      = in_valid & inReady_s;
    assign in_ready   = inReady_s;
    assign stallInc_s = mValid_r & ~take_s & ~kill_s;

    generate
        if (SKID) begin : g_skid
            logic             sValid_r;
            logic [WIDTH-1:0] sData_r;

            // Ready comes straight off the skid flop, so no path from downstream.
            assign inReady_s = ~sValid_r;

            // Main/skid entries: skid always drains into main before new beats.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mValid_r <= 1'b0;
                    mData_r  <= '0;
                    sValid_r <= 1'b0;
                    sData_r  <= '0;
                end else if (kill_s) begin
                    mValid_r <= 1'b0;
                    sValid_r <= 1'b0;
                    if (ZERO_ON_FLUSH) begin
                        mData_r <= '0;
                        sData_r <= '0;
                    end else begin
                        mData_r <= mData_r;
                        sData_r <= sData_r;
                    end
                end else if (take_s) begin
                    if (sValid_r) begin
                        mValid_r <= 1'b1;
                        mData_r  <= sData_r;
                        sValid_r <= 1'b0;
                    end else begin
                        mValid_r <= acc_s;
                        mData_r  <= acc_s ? in_data : mData_r;
                    end
                end else if (acc_s && !mValid_r) begin
                    mValid_r <= 1'b1;
                    mData_r  <= in_data;
                end else if (acc_s) begin
                    sValid_r <= 1'b1;
                    sData_r  <= in_data;
                end else begin
                    mValid_r <= mValid_r;
                    sValid_r <= sValid_r;
                end
            end
        end else begin : g_single
            assign inReady_s = ~mValid_r | take_s;

            // Single entry: reload whenever the held beat leaves or none is held.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mValid_r <= 1'b0;
                    mData_r  <= '0;
                end else if (kill_s) begin
                    mValid_r <= 1'b0;
                    mData_r  <= ZERO_ON_FLUSH ? '0 : mData_r;
                end else if (take_s || !mValid_r) begin
                    mValid_r <= acc_s;
                    mData_r  <= acc_s ? in_data : mData_r;
                end else begin
                    mValid_r <= mValid_r;
                    mData_r  <= mData_r;
                end
            end
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallInc_s),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_xferCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_s),
        .clr   (cnt_clr),
        .cnt   (xfer_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three configurations (skid, single-entry, 4-bit
// counters) share one stimulus and are compared against a FIFO-level model.
module tb_pipe_stage_buf;

    localparam int W = 22;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         iv     = 1'b0;
    logic         ordy   = 1'b0;
    logic         stall  = 1'b0;
    logic         flush  = 1'b0;
    logic         clr    = 1'b0;
    logic [W-1:0] id     = '0;

    logic         rdyA, vA, rdyB, vB, rdyC, vC;
    logic [W-1:0] dA, dB, dC;
    logic [15:0]  scA, xcA, scB, xcB;
    logic [3:0]   scC, xcC;

    int nErrs   = 0;
    int nChecks = 0;
    bit chkEn   = 1'b0;
    bit collA   = 1'b0;
    bit collB   = 1'b0;
    logic [W-1:0] seqA[$];
    logic [W-1:0] seqB[$];

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (single).
    bit           mSkid [3] = '{1'b1, 1'b0, 1'b1};
    int           mMax  [3] = '{65535, 65535, 15};
    int           mN    [3];
    logic [W-1:0] mQ0   [3];
    logic [W-1:0] mQ1   [3];
    logic [W-1:0] mHead [3];
    int           mSc   [3];
    int           mXc   [3];

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(W), .SKID(1'b1), .ZERO_ON_FLUSH(1'b1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdyA), .in_data(id),
        .out_valid(vA), .out_ready(ordy), .out_data(dA), .stall(stall), .flush(flush),
        .cnt_clr(clr), .stall_cnt(scA), .xfer_cnt(xcA));

    pipe_stage_buf #(.WIDTH(W), .SKID(1'b0), .ZERO_ON_FLUSH(1'b1), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdyB), .in_data(id),
        .out_valid(vB), .out_ready(ordy), .out_data(dB), .stall(stall), .flush(flush),
        .cnt_clr(clr), .stall_cnt(scB), .xfer_cnt(xcB));

    pipe_stage_buf #(.WIDTH(W), .SKID(1'b1), .ZERO_ON_FLUSH(1'b1), .CNT_W(4)) dutC (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdyC), .in_data(id),
        .out_valid(vC), .out_ready(ordy), .out_data(dC), .stall(stall), .flush(flush),
        .cnt_clr(clr), .stall_cnt(scC), .xfer_cnt(xcC));

    function automatic bit expTake(int i);
        return (mN[i] > 0) && !stall && ordy;
    endfunction

    function automatic bit expRdy(int i);
        return mSkid[i] ? (mN[i] < 2) : ((mN[i] == 0) || expTake(i));
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic cmp(input string n, input int i, input logic v, input logic [W-1:0] d,
                       input logic r, input logic [31:0] sc, input logic [31:0] xc);
        chk({n, " out_valid"}, 32'(v), 32'((mN[i] > 0) && !stall));
        chk({n, " out_data"},  32'(d), 32'(mHead[i]));
        chk({n, " in_ready"},  32'(r), 32'(expRdy(i)));
        chk({n, " stall_cnt"}, sc, 32'(mSc[i]));
        chk({n, " xfer_cnt"},  xc, 32'(mXc[i]));
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    task automatic edgeStep();
        @(posedge clk);
        #2;
    endtask

    // Model update at each active edge, cleared by the asynchronous reset.
    initial begin
        bit t, a, st;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    mN[i] = 0; mHead[i] = '0; mSc[i] = 0; mXc[i] = 0;
                end else begin
                    t  = expTake(i);
                    a  = iv && expRdy(i);
                    st = (mN[i] > 0) && !t && !flush;
                    if (flush) begin
                        mN[i] = 0;
                        mHead[i] = '0;
                    end else begin
                        if (t) begin
                            mQ0[i] = mQ1[i];
                            mN[i]--;
                        end
                        if (a) begin
                            if (mN[i] == 0) mQ0[i] = id;
                            else            mQ1[i] = id;
                            mN[i]++;
                        end
                        if (mN[i] > 0) mHead[i] = mQ0[i];
                    end
                    if (clr) begin
                        mSc[i] = 0; mXc[i] = 0;
                    end else begin
                        if (st && mSc[i] < mMax[i]) mSc[i]++;
                        if (t && mXc[i] < mMax[i])  mXc[i]++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of all three stages against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chkEn) begin
                cmp("A", 0, vA, dA, rdyA, 32'(scA), 32'(xcA));
                cmp("B", 1, vB, dB, rdyB, 32'(scB), 32'(xcB));
                cmp("C", 2, vC, dC, rdyC, 32'(scC), 32'(xcC));
                if (collA && vA && ordy) seqA.push_back(dA);
                if (collB && vB && ordy) seqB.push_back(dB);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nxt;
        int cyc;
        bit acc;

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        chkEn = 1'b1;
        atNeg();
        chk("reset out_valid", 32'(vA), 32'd0);
        chk("reset out_data", 32'(dA), 32'd0);
        chk("reset in_ready skid", 32'(rdyA), 32'd1);
        chk("reset in_ready single", 32'(rdyB), 32'd1);
        chk("reset counters", 32'(scA) + 32'(xcA), 32'd0);
        edgeStep();

        // One-cycle latency through an empty stage.
        iv = 1'b1; id = 22'h2ABCD; ordy = 1'b1;
        atNeg(); edgeStep();
        iv = 1'b0;
        atNeg();
        chk("lat out_valid A", 32'(vA), 32'd1);
        chk("lat out_data A", 32'(dA), 32'h2ABCD);
        chk("lat out_data B", 32'(dB), 32'h2ABCD);
        edgeStep();
        atNeg();
        chk("lat xfer_cnt A", 32'(xcA), 32'd1);
        edgeStep();

        // Skid stream 1..8 with downstream blocked in cycles 3-5.
        nxt = 1; collA = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            ordy = !(c >= 3 && c <= 5);
            iv   = (nxt <= 8);
            id   = W'(nxt);
            atNeg();
            if (c == 3) chk("skid rdy before fill", 32'(rdyA), 32'd1);
            if (c == 4) chk("skid rdy after fill", 32'(rdyA), 32'd0);
            if (c == 7) chk("skid rdy after drain", 32'(rdyA), 32'd1);
            acc = iv && expRdy(0);
            edgeStep();
            if (acc) nxt++;
        end
        collA = 1'b0;
        chk("skid beats delivered", 32'(seqA.size()), 32'd8);
        for (int k = 0; k < seqA.size(); k++) chk("skid order", 32'(seqA[k]), 32'(k + 1));
        atNeg();
        chk("skid stall_cnt", 32'(scA), 32'd3);
        chk("skid xfer_cnt", 32'(xcA), 32'd9);
        edgeStep();

        // Hazard stall holds the beat and masks out_valid.
        iv = 1'b1; id = 22'h155; stall = 1'b1; ordy = 1'b1;
        atNeg(); edgeStep();
        iv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            atNeg();
            chk("stall out_valid", 32'(vA), 32'd0);
            chk("stall out_data", 32'(dA), 32'h155);
            edgeStep();
        end
        stall = 1'b0;
        atNeg();
        chk("stall stall_cnt", 32'(scA), 32'd7);
        chk("stall xfer_cnt held", 32'(xcA), 32'd9);
        edgeStep();
        atNeg();
        chk("stall release xfer", 32'(xcA), 32'd10);
        edgeStep();

        // Flush with both entries full, then with ready high.
        iv = 1'b1; id = 22'h0A1; ordy = 1'b0;
        atNeg(); edgeStep();
        id = 22'h0A2;
        atNeg(); edgeStep();
        id = 22'h0BAD; flush = 1'b1;
        atNeg();
        chk("flush full rdy", 32'(rdyA), 32'd0);
        edgeStep();
        flush = 1'b0; iv = 1'b0;
        atNeg();
        chk("flush out_valid", 32'(vA), 32'd0);
        chk("flush in_ready", 32'(rdyA), 32'd1);
        chk("flush out_data", 32'(dA), 32'd0);
        edgeStep();
        ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            atNeg();
            chk("flush no ghost", 32'(vA), 32'd0);
            edgeStep();
        end
        iv = 1'b1; id = 22'h077; ordy = 1'b0;
        atNeg(); edgeStep();
        id = 22'h0BEEF; flush = 1'b1;
        atNeg();
        chk("flush offer rdy", 32'(rdyA), 32'd1);
        edgeStep();
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        atNeg();
        chk("flush drop out_valid", 32'(vA), 32'd0);
        chk("flush drop out_data", 32'(dA), 32'd0);
        chk("flush stall_cnt", 32'(scA), 32'd8);
        edgeStep();

        // Single-entry stage under toggling out_ready.
        nxt = 0; cyc = 0; collB = 1'b1;
        while (seqB.size() < 16 && cyc < 80) begin
            ordy = (cyc % 2 == 0);
            iv   = (nxt < 16);
            id   = W'(32'h300 + nxt);
            atNeg();
            acc = iv && expRdy(1);
            edgeStep();
            if (acc) nxt++;
            cyc++;
        end
        collB = 1'b0;
        chk("single beats delivered", 32'(seqB.size()), 32'd16);
        for (int k = 0; k < seqB.size(); k++) chk("single order", 32'(seqB[k]), 32'(32'h300 + k));

        // Counter saturation on the 4-bit instance, then clear.
        iv = 1'b1; id = 22'h03C; ordy = 1'b0;
        atNeg(); edgeStep();
        iv = 1'b0;
        repeat (20) begin atNeg(); edgeStep(); end
        atNeg();
        chk("sat stall_cnt C", 32'(scC), 32'd15);
        edgeStep();
        clr = 1'b1;
        atNeg(); edgeStep();
        clr = 1'b0;
        atNeg();
        chk("clr stall_cnt C", 32'(scC), 32'd0);
        chk("clr xfer_cnt C", 32'(xcC), 32'd0);
        chk("clr stall_cnt A", 32'(scA), 32'd0);
        edgeStep();
        atNeg();
        chk("clr restart C", 32'(scC), 32'd1);
        edgeStep();

        // Asynchronous reset in the middle of a stream.
        ordy = 1'b1; iv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id = W'(32'h400 + k);
            atNeg(); edgeStep();
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(vA) + 32'(vB) + 32'(vC), 32'd0);
        chk("async rst out_data A", 32'(dA), 32'd0);
        chk("async rst out_data B", 32'(dB), 32'd0);
        chk("async rst in_ready", 32'(rdyA) + 32'(rdyB) + 32'(rdyC), 32'd3);
        chk("async rst counters", 32'(xcA) + 32'(scA) + 32'(xcB) + 32'(scC), 32'd0);
        repeat (2) edgeStep();
        rst_n = 1'b1; iv = 1'b0;
        repeat (3) begin atNeg(); edgeStep(); end

        $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register replacing the fixed per-stage latches (e.g. MEM/WB): generic payload width, valid/ready handshake, optional 2-entry skid buffer, stall hold, flush, and saturating occupancy counters.
- Sits between any two pipeline stages.
- The payload is opaque: we/addr/data/hlt are packed by the instantiating stage.

Parameters:
- WIDTH, 22: payload bits (default = hlt + we + dst_addr[3:0] + dst_data[15:0]).
- SKID, 1: 1 = registered in_ready with skid entry; 0 = single entry, combinational in_ready.
- ZERO_ON_FLUSH, 1: 1 = flush also zeroes stored payloads; 0 = only valid bits cleared.
- CNT_W, 16: width of the performance counters.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: upstream beat valid.
- in_ready, out, 1: stage can accept a beat.
- in_data, in, WIDTH: upstream payload.
- out_valid, out, 1: beat presented downstream.
- out_ready, in, 1: downstream accepts.
- out_data, out, WIDTH: payload presented downstream.
- stall, in, 1: hazard-unit hold; masks out_valid.
- flush, in, 1: kill all beats held in the stage.
- cnt_clr, in, 1: synchronous clear of both counters.
- stall_cnt, out, CNT_W: cycles a beat was held (not taken).
- xfer_cnt, out, CNT_W: beats delivered downstream.

Behaviour:
- State: main entry (m_v, m_d); skid entry (s_v, s_d), which exists only when SKID=1.
- Reset (async, rst_n=0): m_v, s_v, m_d, s_d, stall_cnt and xfer_cnt = 0; out_valid=0, out_data=0, in_ready=1 (both modes).
- out_valid = m_v & ~stall; out_data = m_d (held stable while stalled).
- take = out_valid & out_ready; acc = in_valid & in_ready.
- in_ready, SKID=1: ~s_v, a registered flop, with no combinational path from out_ready/stall.
- in_ready, SKID=0: ~m_v | take (combinational).
- Priority per clock: flush > take/acc.
- flush=1:
  - m_v, s_v <= 0.
  - m_d, s_d <= 0 if ZERO_ON_FLUSH.
  - Any beat offered that cycle is dropped, even if in_ready=1. The upstream stage is flushed by the same hazard unit.
- SKID=1, take=1:
  - s_v=1 -> m <= s, s_v <= 0 (acc impossible, in_ready=0).
  - s_v=0 -> m_v <= acc; m_d <= in_data if acc.
- SKID=1, take=0:
  - acc & ~m_v -> m <= in, m_v <= 1.
  - acc & m_v -> s <= in, s_v <= 1 (in_ready drops next cycle).
- SKID=0:
  - take | ~m_v -> m_v <= acc, m_d <= in_data when acc.
  - Otherwise hold.
- Latency and throughput:
  - 1 cycle in_data -> out_data when empty.
  - Full throughput, 1 beat/cycle, with out_ready=1 and stall=0, in both modes.
- Ordering: strictly FIFO; the skid beat is always older than any new beat. No duplicate or lost beat except on flush.
- Stall with empty stage: no effect; counters unchanged.
- Counters:
  - stall_cnt += 1 when m_v & ~take & ~flush.
  - xfer_cnt += 1 when take.
  - Both saturate at 2^CNT_W-1, with no wrap.
  - cnt_clr has priority over increment and is independent of flush.
- Reset mid-operation: immediate clear of all state; counters restart at 0.

Decomposition:
- Shared package pipe_pkg:
  - Widths DATA_W=16, REGADDR_W=4, WB_PAYLOAD_W=22.
  - Packed typedef wb_payload_t {hlt, we, dst_addr, dst_data}.
  - Flush/stall encoding constants.
- One natural sub-module: sat_counter (CNT_W, inc, clr -> cnt), instantiated twice.

Test Plan:
- Reset, then in_valid=1, in_data=0x2ABCD, out_ready=1 -> out_valid=1 and out_data=0x2ABCD on the next cycle; xfer_cnt=1 after take.
- SKID=1: stream 0x1..0x8 back-to-back with out_ready=0 at cycles 3-5:
  - in_ready falls one cycle after the skid fills.
  - Output sequence is exactly 0x1..0x8, no gaps after release.
  - stall_cnt=3.
- stall=1 for 4 cycles with m_v=1, out_ready=1 -> out_valid=0, out_data constant, stall_cnt=4, xfer_cnt unchanged.
- Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=0 (ZERO_ON_FLUSH=1); the offered beat never appears.
- SKID=0: out_ready toggled 1/0 each cycle with in_valid=1 -> in_ready mirrors take in the same cycle; no beat lost or duplicated over 16 beats.
- CNT_W=4: hold a beat 20 cycles -> stall_cnt saturates at 15. cnt_clr pulse -> 0 next cycle. rst_n low mid-stream -> all outputs 0 asynchronously.
